pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Control FSM that sequences the program counter of the pico-MIPS core. It takes decoded instruction-class flags from the instruction decoder and drives the `pc` block's `halt`, `rel_branch` and `offset` inputs combinationally. It handles multi-cycle instructions, external-input wait instructions and halt/resume, and it emits a per-instruction commit strobe for register write-back. It sits between the decoder and `pc`. The top level ties `pc.n_reset = ~reset`.

## Interface
- `AddrSz`, default 6: program address width; also the width of the branch offset.
- `McW`, default 4: width of the multi-cycle count field.

- `clk`  in  1: system clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `stop_req`  in  1: current instruction is HALT.
- `wait_req`  in  1: current instruction waits for external data.
- `ext_valid`  in  1: external data available.
- `mc_req`  in  1: current instruction is multi-cycle.
- `mc_cycles`  in  McW: extra cycles needed by the multi-cycle instruction.
- `branch_req`  in  1: current instruction is a relative branch.
- `branch_cond`  in  1: branch condition (ALU flag), valid in the same cycle.
- `branch_offset`  in  AddrSz: two's-complement branch offset.
- `resume`  in  1: leave the halted state.
- `pc_halt`  out  1: to `pc.halt`.
- `pc_rel_branch`  out  1: to `pc.rel_branch`.
- `pc_offset`  out  AddrSz: to `pc.offset`.
- `commit`  out  1: current instruction retires this cycle; gates register write enable.
- `ext_ack`  out  1: external data consumed this cycle.
- `busy`  out  1: state is not S_RUN.

## Operation
- States: S_INIT, S_RUN, S_MC, S_WAIT, S_HALT. There is one down-counter `mc_cnt` of width McW.
- Reset sets state to S_INIT and `mc_cnt` to 0.
- Outputs are Mealy (combinational from state and inputs). `pc_offset` equals `branch_offset` when `pc_rel_branch` is 1, else 0.
- Default output values are `pc_halt=0`, `pc_rel_branch=0`, `commit=0`, `ext_ack=0`.

**S_INIT**
- `pc_halt=1`.
- Next state is S_RUN.
- This holds PC for the first cycle after reset.

**S_RUN** evaluates its inputs in strict priority order:
1. `stop_req`: `pc_halt=1`, `commit=1`; next state S_HALT.
2. `wait_req`:
   - If `ext_valid`: `ext_ack=1`, `commit=1`, PC increments; stay in S_RUN.
   - Otherwise: `pc_halt=1`; next state S_WAIT.
3. `mc_req` with `mc_cycles != 0`: `pc_halt=1`, `mc_cnt <= mc_cycles`; next state S_MC. With `mc_cycles == 0`, `mc_req` is treated as a single-cycle instruction.
4. `branch_req`: `pc_rel_branch = branch_cond`, `commit=1`.
5. Otherwise: `commit=1`, PC increments.

**S_MC**
- If `mc_cnt == 1`: `pc_halt=0`, `commit=1`; next state S_RUN.
- Otherwise: `pc_halt=1`, `mc_cnt` decrements.
- A multi-cycle instruction therefore occupies `mc_cycles + 1` cycles and commits exactly once, in its last cycle.
- `branch_req` is ignored while in S_MC.

**S_WAIT**
- `pc_halt=1` until `ext_valid` is seen.
- On `ext_valid`: `pc_halt=0`, `ext_ack=1`, `commit=1`; next state S_RUN.

**S_HALT**
- `pc_halt=1`.
- On `resume`: `pc_halt=0` (PC moves past the HALT instruction); next state S_RUN.
- `commit` stays 0 in this state; the HALT instruction already committed on entry.

**General rules**
- `busy` is 1 in every state except S_RUN.

## Timing
- Zero-latency control: outputs affect the PC at the same posedge at which the controller updates state.
- Offset arithmetic is performed inside `pc`, modulo 2^AddrSz. The controller passes the offset unchanged.
  - An offset of 0 with a taken branch is a legal self-loop, not a halt.
  - Negative offsets wrap normally, e.g. address 2 + 6'h3E gives address 0.
- `ext_ack` is a single-cycle pulse. It is asserted in the same cycle as the matching `commit` and PC advance.
- `ext_valid` that arrives while in S_MC or S_HALT is ignored and not latched.
- Simultaneous `stop_req` and `wait_req` in S_RUN: stop wins, and `ext_ack` stays 0.
- `resume` in any state other than S_HALT is ignored.
- Reset in any state, including S_MC and S_WAIT, gives S_INIT on the next cycle:
  - `mc_cnt` is cleared;
  - no `commit` or `ext_ack` is produced during the reset cycle.
- Output values while `reset` is high are the S_INIT values, so `pc_halt=1`.

## Structure
- Shared package `pico_ctrl_pkg` holds:
  - enum `seq_state_t` with states S_INIT, S_RUN, S_MC, S_WAIT, S_HALT;
  - constants `ADDR_SZ_DEF = 6` and `MC_W_DEF = 4`.
- Sub-module `mc_counter` (load, decrement, `is_one` flag; width McW) implements the stall counter.
- The FSM and output logic sit in `pc_sequencer`.

## Test plan
- **Reset and run.** Pulse `reset` for 2 cycles with all request inputs at 0.
  - Expect `pc_halt=1` for exactly one cycle after reset falls.
  - Then the `pc` address increments by 1 each cycle, with `commit=1`.
- **Branch.** At address 5, assert `branch_req=1`, `branch_cond=1`, `branch_offset=10`.
  - Expect address 15 on the next cycle and `commit=1`.
  - Repeat with `branch_cond=0`: expect address 6.
  - Repeat with offset 6'h3E from address 2: expect address 0.
- **Multi-cycle.** `mc_req=1`, `mc_cycles=3` at address 4.
  - Expect the address to stay 4 for 4 cycles.
  - Expect `commit` high only in the 4th cycle.
  - Then the address becomes 5.
- **External wait.** `wait_req=1`, with `ext_valid` raised 3 cycles later.
  - Expect `busy=1` and the address held in the meantime.
  - Then one cycle with `ext_ack=1` and `commit=1`, and the address advances by 1.
- **Halt and resume.** `stop_req=1` at address 9.
  - Expect the address held at 9 for 50 cycles.
  - A `resume` pulse moves the address to 10; `commit` pulses only once, at entry to S_HALT.
- **Reset mid-operation.** Assert `reset` during S_MC with `mc_cnt=2`.
  - Expect S_INIT next, `mc_cnt=0`, and no `commit`.
  - Normal increment resumes after the S_INIT cycle.

Source files
------------

// File: rtl/pico_ctrl_pkg.sv
// pico_ctrl_pkg: shared state encoding and default widths for the pico-MIPS control path
package pico_ctrl_pkg;
  typedef enum logic [2:0] {S_INIT, S_RUN, S_MC, S_WAIT, S_HALT} seq_state_t;
  localparam int ADDR_SZ_DEF = 6;
  localparam int MC_W_DEF = 4;
endpackage

// File: rtl/pc_sequencer_mc_counter.sv
// mc_counter: loadable down-counter that flags the final stall cycle of a multi-cycle instruction
module mc_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic         is_one
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= reset ? '0 : load ? din : dec ? cnt - W'(1) : cnt;
  assign is_one = cnt == W'(1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: Mealy control FSM driving pc halt/branch and per-instruction commit
module pc_sequencer
  import pico_ctrl_pkg::*;
#(
  parameter int AddrSz = ADDR_SZ_DEF,
  parameter int McW    = MC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stop_req,
  input  logic              wait_req,
  input  logic              ext_valid,
  input  logic              mc_req,
  input  logic [McW-1:0]    mc_cycles,
  input  logic              branch_req,
  input  logic              branch_cond,
  input  logic [AddrSz-1:0] branch_offset,
  input  logic              resume,
  output logic              pc_halt,
  output logic              pc_rel_branch,
  output logic [AddrSz-1:0] pc_offset,
  output logic              commit,
  output logic              ext_ack,
  output logic              busy
);
  seq_state_t state, cur, nxt;
  logic mc_load, mc_dec, mc_one;
  // reset forces the S_INIT outputs in the same cycle, not just on the next one
  assign cur = reset ? S_INIT : state;
  always_comb begin
    nxt = cur;
    pc_halt = 1'b0;
    pc_rel_branch = 1'b0;
    commit = 1'b0;
    ext_ack = 1'b0;
    mc_load = 1'b0;
    case (cur)
      S_INIT: begin
        pc_halt = 1'b1;
        nxt = S_RUN;
      end
      S_RUN:
        if (stop_req) begin
          pc_halt = 1'b1;
          commit = 1'b1;
          nxt = S_HALT;
        end else if (wait_req) begin
          pc_halt = !ext_valid;
          ext_ack = ext_valid;
          commit = ext_valid;
          nxt = ext_valid ? S_RUN : S_WAIT;
        end else if (mc_req && mc_cycles != '0) begin
          pc_halt = 1'b1;
          mc_load = 1'b1;
          nxt = S_MC;
        end else begin
          pc_rel_branch = branch_req & branch_cond;
          commit = 1'b1;
        end
      S_MC: begin
        pc_halt = !mc_one;
        commit = mc_one;
        nxt = mc_one ? S_RUN : S_MC;
      end
      S_WAIT: begin
        pc_halt = !ext_valid;
        ext_ack = ext_valid;
        commit = ext_valid;
        nxt = ext_valid ? S_RUN : S_WAIT;
      end
      S_HALT: begin
        pc_halt = !resume;
        nxt = resume ? S_RUN : S_HALT;
      end
      default: nxt = S_INIT;
    endcase
  end
  assign mc_dec = cur == S_MC && !mc_one;
  assign pc_offset = pc_rel_branch ? branch_offset : '0;
  assign busy = cur != S_RUN;
  always_ff @(posedge clk)
    state <= reset ? S_INIT : nxt;
  mc_counter #(.W(McW)) u_mc (
    .clk(clk),
    .reset(reset),
    .load(mc_load),
    .dec(mc_dec),
    .din(mc_cycles),
    .is_one(mc_one)
  );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus checked against an instruction-level reference model
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset, stop_req, wait_req, ext_valid, mc_req, branch_req, branch_cond, resume;
  logic [3:0] mc_cycles;
  logic [5:0] branch_offset;
  logic pc_halt, pc_rel_branch, commit, ext_ack, busy;
  logic [5:0] pc_offset;
  logic [5:0] dut_addr;
  int n_cmp = 0, n_bad = 0;
  bit m_init, m_halted, m_waiting;
  int m_stall;
  logic [5:0] m_addr, saved;
  logic e_halt, e_rel, e_commit, e_ack, e_busy;
  logic [5:0] e_off;
  int commits;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stop_req(stop_req), .wait_req(wait_req),
    .ext_valid(ext_valid), .mc_req(mc_req), .mc_cycles(mc_cycles),
    .branch_req(branch_req), .branch_cond(branch_cond), .branch_offset(branch_offset),
    .resume(resume), .pc_halt(pc_halt), .pc_rel_branch(pc_rel_branch),
    .pc_offset(pc_offset), .commit(commit), .ext_ack(ext_ack), .busy(busy)
  );

  always @(posedge clk)
    dut_addr <= reset ? 6'd0 : pc_halt ? dut_addr : pc_rel_branch ? dut_addr + pc_offset : dut_addr + 6'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    {reset, stop_req, wait_req, ext_valid, mc_req, branch_req, branch_cond, resume} = '0;
    mc_cycles = '0;
    branch_offset = '0;
  endtask

  task automatic predict();
    {e_halt, e_rel, e_commit, e_ack} = '0;
    e_busy = 1'b1;
    if (reset || m_init) e_halt = 1'b1;
    else if (m_halted) e_halt = !resume;
    else if (m_waiting) begin
      e_halt = !ext_valid;
      e_ack = ext_valid;
      e_commit = ext_valid;
    end else if (m_stall > 0) begin
      e_halt = m_stall != 1;
      e_commit = m_stall == 1;
    end else begin
      e_busy = 1'b0;
      if (stop_req) {e_halt, e_commit} = 2'b11;
      else if (wait_req) begin
        e_halt = !ext_valid;
        e_ack = ext_valid;
        e_commit = ext_valid;
      end else if (mc_req && mc_cycles != 0) e_halt = 1'b1;
      else begin
        e_commit = 1'b1;
        e_rel = branch_req & branch_cond;
      end
    end
    e_off = e_rel ? branch_offset : 6'd0;
  endtask

  task automatic advance();
    bit was_run;
    was_run = !reset && !m_init && !m_halted && !m_waiting && m_stall == 0;
    m_addr = reset ? 6'd0 : e_halt ? m_addr : m_addr + (e_rel ? e_off : 6'd1);
    if (reset) begin
      m_init = 1; m_halted = 0; m_waiting = 0; m_stall = 0;
    end else if (m_init) m_init = 0;
    else if (m_halted) m_halted = !resume;
    else if (m_waiting) m_waiting = !ext_valid;
    else if (m_stall > 0) m_stall--;
    else if (was_run) begin
      if (stop_req) m_halted = 1;
      else if (wait_req) m_waiting = !ext_valid;
      else if (mc_req && mc_cycles != 0) m_stall = mc_cycles;
    end
  endtask

  task automatic tick();
    #4;
    predict();
    check("pc_halt", pc_halt, e_halt);
    check("rel_branch", pc_rel_branch, e_rel);
    check("offset", pc_offset, e_off);
    check("commit", commit, e_commit);
    check("ext_ack", ext_ack, e_ack);
    check("busy", busy, e_busy);
    if (!reset && !m_init) check("addr", dut_addr, m_addr);
    commits += commit;
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic randomize_inputs();
    reset = $urandom_range(0, 99) == 0;
    stop_req = $urandom_range(0, 19) == 0;
    wait_req = $urandom_range(0, 7) == 0;
    ext_valid = $urandom_range(0, 2) == 0;
    mc_req = $urandom_range(0, 5) == 0;
    mc_cycles = 4'($urandom_range(0, 5));
    branch_req = $urandom_range(0, 3) == 0;
    branch_cond = 1'($urandom);
    branch_offset = 6'($urandom);
    resume = $urandom_range(0, 3) == 0;
  endtask

  initial begin
    commits = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    idle();
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("addr_at_5", dut_addr, 6'd5);
    branch_req = 1'b1; branch_cond = 1'b1; branch_offset = 6'd10;
    tick();
    check("branch_taken", dut_addr, 6'd15);
    branch_cond = 1'b0;
    tick();
    check("branch_not_taken", dut_addr, 6'd16);
    branch_cond = 1'b1; branch_offset = 6'h3E;
    tick();
    check("branch_neg", dut_addr, 6'd14);
    idle();
    mc_req = 1'b1; mc_cycles = 4'd3;
    commits = 0;
    saved = m_addr;
    for (int i = 0; i < 4; i++) begin
      tick();
      mc_req = 1'b0; branch_req = 1'b1; ext_valid = 1'b1;
    end
    check("mc_commits", commits, 1);
    check("mc_addr", dut_addr, saved + 6'd1);
    idle();
    wait_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ext_valid = 1'b1;
    tick();
    idle();
    stop_req = 1'b1;
    saved = m_addr;
    commits = 0;
    tick();
    stop_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      randomize_inputs();
      reset = 1'b0; resume = 1'b0;
      tick();
    end
    check("halt_hold", dut_addr, saved);
    idle();
    resume = 1'b1;
    tick();
    check("resume_addr", dut_addr, saved + 6'd1);
    check("halt_commits", commits, 1);
    idle();
    mc_req = 1'b1; mc_cycles = 4'd3;
    tick();
    idle();
    tick();
    reset = 1'b1;
    tick();
    idle();
    tick();
    tick();
    check("post_reset_addr", dut_addr, 6'd1);
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
